// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC-3 memory port between the CPU (MIO) path and a DMA port.
// Each access holds mem_en for WAIT_CYCLES cycles. Define LC3_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module lc3_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_r,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("lc3_mem_arbiter: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              grant_dma_q;
    logic              grant_dma_d;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              cpu_r_q;
    logic              dma_ack_q;

`ifdef LC3_ARB_ROUND_ROBIN_EN
    logic              last_dma_q;

    // On contention the side that did not win last time goes first.
    always_comb begin
        grant_dma_d = dma_req && (!cpu_req || !last_dma_q);
    end
`else
    always_comb begin
        grant_dma_d = dma_req && !cpu_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            grant_dma_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_r_q     <= 1'b0;
            dma_ack_q   <= 1'b0;
`ifdef LC3_ARB_ROUND_ROBIN_EN
            last_dma_q  <= 1'b1;
`endif
        end else begin
            cpu_r_q   <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        grant_dma_q <= grant_dma_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_dma_d ? dma_we    : cpu_we;
                        mem_addr_q  <= grant_dma_d ? dma_addr  : cpu_addr;
                        mem_wdata_q <= grant_dma_d ? dma_wdata : cpu_wdata;
                        cnt_q       <= WAIT_INIT;
                        state_q     <= ACCESS;
`ifdef LC3_ARB_ROUND_ROBIN_EN
                        last_dma_q  <= grant_dma_d;
`endif
                    end else begin
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        // Memory data is only valid on the last enabled cycle.
                        if (!mem_we_q) begin
                            if (grant_dma_q) dma_rdata_q <= mem_rdata;
                            else             cpu_rdata_q <= mem_rdata;
                        end
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (grant_dma_q) dma_ack_q <= 1'b1;
                        else             cpu_r_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_r     = cpu_r_q;
    assign dma_ack   = dma_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed vector table, hand-written contention/reset sequences and
// randomized traffic against a transaction-level timing model (honours LC3_ARB_ROUND_ROBIN_EN).
module tb_lc3_mem_arbiter;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_r, dma_ack, mem_en, mem_we, busy;

    always #5 clk = ~clk;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [15:0] phys_mem [0:65535];
    logic [15:0] ref_mem  [0:65535];

    int tests, fails, n;

    // Transaction-level model: a grant at cycle g gives mem_en in g+1..g+W, ack at g+W+1,
    // and the arbiter is free again at g+W+2.
    bit          act, t_dma, t_we, last_dma, exp_cpu_r, exp_dma_ack;
    int          g, free_at;
    logic [15:0] t_addr, t_wdata, t_rd, e_cpu_rd, e_dma_rd;

    typedef struct {
        bit          dma;
        bit          we;
        bit          pre;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] preload;
        logic [15:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, n, got, exp);
        end
    endtask

    task automatic model_update();
        if (!reset) begin
            act      = 1'b0;
            free_at  = n + 1;
            e_cpu_rd = 16'h0;
            e_dma_rd = 16'h0;
            last_dma = 1'b1;
        end else if (n >= free_at && (cpu_req || dma_req)) begin
`ifdef LC3_ARB_ROUND_ROBIN_EN
            t_dma = (cpu_req && dma_req) ? !last_dma : dma_req;
`else
            t_dma = !cpu_req;
`endif
            last_dma = t_dma;
            t_we     = t_dma ? dma_we    : cpu_we;
            t_addr   = t_dma ? dma_addr  : cpu_addr;
            t_wdata  = t_dma ? dma_wdata : cpu_wdata;
            act      = 1'b1;
            g        = n;
            free_at  = n + W + 2;
            if (t_we) ref_mem[t_addr] = t_wdata;
            t_rd = ref_mem[t_addr];
        end
    endtask

    task automatic model_check();
        bit en, ack, bsy;
        en  = act && (n >= g + 1) && (n <= g + W);
        ack = act && (n == g + W + 1);
        bsy = en || ack;
        exp_cpu_r   = ack && !t_dma;
        exp_dma_ack = ack && t_dma;
        if (ack && !t_we) begin
            if (t_dma) e_dma_rd = t_rd;
            else       e_cpu_rd = t_rd;
        end
        chk("mem_en",    32'(mem_en),    32'(en));
        chk("mem_we",    32'(mem_we),    32'(en && t_we));
        chk("busy",      32'(busy),      32'(bsy));
        chk("cpu_r",     32'(cpu_r),     32'(exp_cpu_r));
        chk("dma_ack",   32'(dma_ack),   32'(exp_dma_ack));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rd));
        chk("dma_rdata", 32'(dma_rdata), 32'(e_dma_rd));
        if (en) begin
            chk("mem_addr",  32'(mem_addr),  32'(t_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(t_wdata));
        end
        if (ack)
            $display("[TB] cycle %0d: %s %s addr=%h data=%h", n, t_dma ? "DMA" : "CPU",
                     t_we ? "write" : "read ", t_addr, t_we ? t_wdata : t_rd);
    endtask

    // Advance one clock; memory behaves as an array written while mem_en && mem_we.
    task automatic tick();
        if (mem_en && mem_we) phys_mem[mem_addr] = mem_wdata;
        model_update();
        @(posedge clk);
        #1;
        n++;
        mem_rdata = mem_en ? phys_mem[mem_addr] : 16'h0;
        model_check();
    endtask

    task automatic run_vector(input int i);
        vec_t v;
        int   lat, en_cnt;
        bit   got, other;
        v = vecs[i];
        if (v.pre) begin
            phys_mem[v.addr] = v.preload;
            ref_mem[v.addr]  = v.preload;
        end
        if (v.dma) begin
            dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        lat = 0; en_cnt = 0; got = 1'b0; other = 1'b0;
        while (!got && lat < 12) begin
            tick();
            lat++;
            if (mem_en) begin
                en_cnt++;
                chk("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
                chk("vec_mem_we",   32'(mem_we),   32'(v.we));
            end
            if (v.dma ? cpu_r : dma_ack) other = 1'b1;
            got = v.dma ? dma_ack : cpu_r;
        end
        chk("vec_ack_seen",  32'(got),    32'(1));
        chk("vec_latency",   32'(lat),    32'(v.exp_lat));
        chk("vec_en_cycles", 32'(en_cnt), 32'(W));
        chk("vec_other_ack", 32'(other),  32'(0));
        chk("vec_rdata", 32'(v.dma ? dma_rdata : cpu_rdata), 32'(v.exp_rd));
        $display("[TB] vector %0d: %s %s addr=%h latency=%0d rdata=%h", i, v.dma ? "DMA" : "CPU",
                 v.we ? "write" : "read ", v.addr, lat, v.dma ? dma_rdata : cpu_rdata);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic seq_simultaneous();
        int cpu_at, dma_at;
        reset = 1'b0; tick();
        reset = 1'b1; tick();
        phys_mem[16'h3002] = 16'h1111; ref_mem[16'h3002] = 16'h1111;
        phys_mem[16'hFE08] = 16'h2222; ref_mem[16'hFE08] = 16'h2222;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3002; cpu_wdata = 16'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'hFE08; dma_wdata = 16'h0;
        cpu_at = 0; dma_at = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (cpu_at > 0) cpu_req = 1'b0;
            if (dma_at > 0) dma_req = 1'b0;
            if (cpu_r && cpu_at == 0)   cpu_at = k;
            if (dma_ack && dma_at == 0) dma_at = k;
        end
        chk("sim_cpu_ack_cycle", 32'(cpu_at), 32'(W + 1));
        chk("sim_dma_ack_cycle", 32'(dma_at), 32'(2 * W + 3));
        chk("sim_cpu_rdata", 32'(cpu_rdata), 32'(16'h1111));
        chk("sim_dma_rdata", 32'(dma_rdata), 32'(16'h2222));
        $display("[TB] simultaneous: cpu_r at %0d, dma_ack at %0d", cpu_at, dma_at);
    endtask

    task automatic seq_reset_abort();
        bit seen;
        phys_mem[16'h3004] = 16'h7777; ref_mem[16'h3004] = 16'h7777;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3004;
        tick();
        chk("abort_mem_en_before", 32'(mem_en), 32'(1));
        reset = 1'b0;
        cpu_req = 1'b0;
        tick();
        chk("abort_mem_en", 32'(mem_en), 32'(0));
        chk("abort_busy",   32'(busy),   32'(0));
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cpu_r || dma_ack) seen = 1'b1;
        end
        chk("abort_no_ack",    32'(seen),      32'(0));
        chk("abort_cpu_rdata", 32'(cpu_rdata), 32'(0));
        $display("[TB] reset during access: ack_seen=%0d", seen);
    endtask

    initial begin
        bit cpu_drop, dma_drop, allow_new;
        for (int i = 0; i < 65536; i++) begin
            phys_mem[i] = 16'h0;
            ref_mem[i]  = 16'h0;
        end
        tests = 0; fails = 0; n = 0;
        act = 1'b0; g = 0; free_at = 0; last_dma = 1'b1;
        t_dma = 1'b0; t_we = 1'b0; t_addr = 16'h0; t_wdata = 16'h0; t_rd = 16'h0;
        e_cpu_rd = 16'h0; e_dma_rd = 16'h0; exp_cpu_r = 1'b0; exp_dma_ack = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
        mem_rdata = 16'h0;

        //          dma   we    pre   addr      wdata     preload   exp_rd    lat
        vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'h1234, 16'h1234, W + 1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'hFE06, 16'h0041, 16'h0000, 16'h0000, W + 1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'hFE06, 16'h0000, 16'h0000, 16'h0041, W + 1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h3000, 16'hA5A5, 16'h0000, 16'h1234, W + 1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h0000, 16'hA5A5, W + 1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, W + 1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h8001, 16'h8001, W + 1};

        reset = 1'b0;
        repeat (3) tick();
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_mem_en",    32'(mem_en),    32'(0));
        chk("rst_mem_addr",  32'(mem_addr),  32'(0));
        chk("rst_cpu_r",     32'(cpu_r),     32'(0));
        chk("rst_dma_ack",   32'(dma_ack),   32'(0));
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vector(i);
        seq_simultaneous();
        seq_reset_abort();

        cpu_drop = 1'b0;
        dma_drop = 1'b0;
        for (int k = 0; k < 620; k++) begin
            tick();
            allow_new = (k < 600);
            if (exp_cpu_r) cpu_drop = 1'b1;
            else if (cpu_drop) begin
                cpu_req = 1'b0; cpu_drop = 1'b0;
            end else if (cpu_req && act && !t_dma && n >= g + 1 && n <= g + W) begin
                cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            end else if (!cpu_req && allow_new && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'h3000 | 16'($urandom_range(0, 7));
                cpu_wdata = 16'($urandom);
            end
            if (exp_dma_ack) dma_drop = 1'b1;
            else if (dma_drop) begin
                dma_req = 1'b0; dma_drop = 1'b0;
            end else if (dma_req && act && t_dma && n >= g + 1 && n <= g + W) begin
                dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
            end else if (!dma_req && allow_new && $urandom_range(0, 2) == 0) begin
                dma_req   = 1'b1;
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = ($urandom_range(0, 1) == 1 ? 16'h3000 : 16'hFE00) |
                            16'($urandom_range(0, 7));
                dma_wdata = 16'($urandom);
            end
        end
        chk("end_idle_busy",    32'(busy),    32'(0));
        chk("end_idle_cpu_req", 32'(cpu_req), 32'(0));
        chk("end_idle_dma_req", 32'(dma_req), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
